fixed_point_mul_seq: RTL
========================

# fixed_point_mul_seq

Iterative signed fixed-point multiplier, the inverse counterpart of the sequential fixed-point divider: it computes P = A·B in Qm.FRAC_BITS format using one shift-and-add step per clock. It uses the same valid/busy/done handshake and saturation flagging as the divider, so datapath stages can chain the two directly. Typical uses are Q·B checks of divider output and slow dot-product paths where DSP slices are scarce.

## Interface
- WIDTH, 32: total bits of A, B, P (two's complement).
- FRAC_BITS, 14: fractional bits shared by A, B and P; 0 ≤ FRAC_BITS < WIDTH.
- clk_in  input  1  sole clock; all logic on the rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- valid_in  input  1  request strobe; sampled only while idle.
- A  input  WIDTH  signed multiplicand.
- B  input  WIDTH  signed multiplier.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle completion pulse.
- valid_out  output  1  one-cycle pulse; P is valid and updated in that cycle.
- overflow  output  1  result saturated; same timing as valid_out.
- P  output  WIDTH  signed product; held until the next completion.

## Operation
- States: IDLE, RUN, FINAL.
- IDLE with valid_in=1: latch |A| and |B| as WIDTH-bit unsigned magnitudes, latch sign = A[msb]^B[msb], clear the 2·WIDTH accumulator, set count=0, go to RUN. |−2^(WIDTH−1)| = 2^(WIDTH−1) fits unsigned.
- RUN, each cycle: if multiplier bit[count] is 1, add the multiplicand shifted left by count to the accumulator; count++. Shifting the multiplier right and the multiplicand left is equivalent and acceptable. After WIDTH iterations go to FINAL.
- FINAL: compute mag = acc >> FRAC_BITS (truncate the magnitude, i.e. round toward zero), then:
  - sign=0: if mag > 2^(WIDTH−1)−1, set P = 2^(WIDTH−1)−1 and overflow=1; else P = mag.
  - sign=1: if mag > 2^(WIDTH−1), set P = −2^(WIDTH−1) and overflow=1; else P = −mag.
  - Pulse valid_out and done, then return to IDLE.
- A zero operand follows the normal path: P=0, overflow=0, full latency.
- valid_in while busy is ignored. There is no queueing.

## Timing
- Reset values: busy=0, done=0, valid_out=0, overflow=0, P=0, state IDLE, count=0, accumulator=0.
- valid_in sampled at edge k in IDLE sets busy=1 from edge k+1.
- Edges k+1 … k+WIDTH are the iterations. Edge k+WIDTH+1 is FINAL: P, overflow, valid_out=1 and done=1 are registered, and busy=0.
- Latency from the accepting edge to valid_out is WIDTH+1 cycles (33 at defaults). Throughput is one operation per WIDTH+2 cycles.
- valid_out, done and overflow are high for exactly one cycle. overflow is low at every other time.
- Back-to-back: valid_in high during the valid_out cycle is accepted, since the block is already IDLE.
- rst_in during RUN or FINAL aborts the operation. No valid_out is produced, P is cleared to 0, and the block returns to IDLE on that edge. rst_in wins over a simultaneous valid_in.

## Structure
- Shared package fixed_point_pkg holds:
  - the fx_max(WIDTH) / fx_min(WIDTH) saturation constants,
  - the typedef for the state enum (IDLE, RUN, FINAL), which is also reusable by the divider.
- One natural sub-module: fixed_point_saturate. It is combinational and takes the unsigned magnitude plus sign, returning the signed WIDTH-bit result and the overflow flag. The FINAL stage of the divider reuses it.
- Iteration counter width: $clog2(WIDTH+1).

## Test plan
All values at WIDTH=32, FRAC_BITS=14 (1.0 = 16384).
- A=32768 (2.0), B=49152 (3.0) → P=98304, overflow=0, valid_out exactly 33 cycles after accept, busy high for 33 cycles.
- A=−24576 (−1.5), B=40960 (2.5) → P=−61440; A=−16384, B=−16384 → P=16384.
- Truncation: A=1, B=16383 → P=0; A=−1, B=16383 → P=0 (toward zero); A=3, B=24576 → P=4.
- Saturation: A=2147483647, B=32768 → P=2147483647, overflow=1. A=−2147483648, B=32768 → P=−2147483648, overflow=1. A=−2147483648, B=16384 → P=−2147483648, overflow=0.
- Handshake: valid_in held high continuously → a new op starts on each valid_out cycle, with 34-cycle spacing between valid_out pulses. Changing A/B mid-RUN does not alter the result.
- Reset mid-op: rst_in pulsed at iteration 10 → no valid_out, P=0, busy=0. The next request completes correctly.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions: saturation limits and the iterative
// FSM state encoding used by both the sequential multiplier and divider.
package fixed_point_pkg;

    localparam int FX_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2
    } fx_state_t;

    // Largest positive value of a width-bit two's complement number.
    function automatic logic [FX_MAX_WIDTH-1:0] fx_max(input int width);
        return (FX_MAX_WIDTH'(1) << (width - 1)) - FX_MAX_WIDTH'(1);
    endfunction

    // Bit pattern of the most negative width-bit value (low width bits only).
    function automatic logic [FX_MAX_WIDTH-1:0] fx_min(input int width);
        return FX_MAX_WIDTH'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/fixed_point_saturate.sv
// Converts an unsigned magnitude plus sign into a saturated signed result.
// Shared by the FINAL stage of the sequential multiplier and divider.
module fixed_point_saturate
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MAG_W = 64
) (
    input  logic [MAG_W-1:0] mag,
    input  logic             sign,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(fx_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(fx_min(WIDTH));

    logic pos_big;
    logic neg_big;

    // Positive limit is 2^(W-1)-1; negative limit allows exactly 2^(W-1).
    assign pos_big = |(mag >> (WIDTH - 1));
    assign neg_big = (|(mag >> WIDTH)) || (mag[WIDTH-1] && (|mag[WIDTH-2:0]));

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        if (!sign) begin
            if (pos_big) begin
                result   = MAX_VAL;
                overflow = 1'b1;
            end else begin
                result = mag[WIDTH-1:0];
            end
        end else begin
            if (neg_big) begin
                result   = MIN_VAL;
                overflow = 1'b1;
            end else begin
                result = -mag[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/fixed_point_mul_seq.sv
// Iterative signed fixed-point multiplier: one shift-and-add step per clock,
// magnitude truncated toward zero and saturated to WIDTH bits.
module fixed_point_mul_seq
    import fixed_point_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 14
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             valid_out,
    output logic             overflow,
    output logic [WIDTH-1:0] P
);

    // Handshake: valid_in is accepted on any edge where busy is low (IDLE);
    // while busy it is ignored. valid_out/done pulse for one cycle with P and
    // overflow, and the block is already IDLE in that cycle, so a request
    // presented alongside valid_out starts the next operation immediately.

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH;

    fx_state_t        state;
    fx_state_t        state_next;
    logic [AW-1:0]    mcand;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] mplier;
    logic             sign;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [AW-1:0]    mag;
    logic [WIDTH-1:0] sat_p;
    logic             sat_ovf;
    logic             last_iter;

    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign abs_a     = A[WIDTH-1] ? -A : A;
    assign abs_b     = B[WIDTH-1] ? -B : B;
    assign last_iter = (count == CW'(WIDTH - 1));
    assign mag       = acc >> FRAC_BITS;
    assign busy      = (state != IDLE);

    fixed_point_saturate #(
        .WIDTH (WIDTH),
        .MAG_W (AW)
    ) u_saturate (
        .mag      (mag),
        .sign     (sign),
        .result   (sat_p),
        .overflow (sat_ovf)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid_in) state_next = RUN;
            RUN:     if (last_iter) state_next = FINAL;
            FINAL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            sign      <= 1'b0;
            count     <= '0;
            P         <= '0;
            overflow  <= 1'b0;
            valid_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        mcand  <= {{WIDTH{1'b0}}, abs_a};
                        mplier <= abs_b;
                        sign   <= A[WIDTH-1] ^ B[WIDTH-1];
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                end
                FINAL: begin
                    P         <= sat_p;
                    overflow  <= sat_ovf;
                    valid_out <= 1'b1;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
